// File: rtl/traffic_sensor_conditioner.sv
// Loop-detector conditioning for a two-direction traffic light controller.
// Each direction is synchronized, debounced, latched until served, and watched for a stuck loop.

module traffic_sensor_channel #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int STUCK_CYCLES    = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw,
   input  logic [1:0] light,
   output logic       sensor,
   output logic       fault
);

   // state  | meaning
   // IDLE   | no vehicle seen, waiting for a synchronized high sample
   // QUAL   | counting consecutive high samples toward the debounce limit
   // REQ    | vehicle qualified, request held until the direction turns green
   // SERVED | direction is green; loop ignored until the lamp leaves green
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_QUAL   = 2'd1,
      ST_REQ    = 2'd2,
      ST_SERVED = 2'd3
   } state_t;

   localparam logic [7:0]  QUAL_LAST   = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0] STUCK_MAX   = 16'(STUCK_CYCLES);
   localparam logic [1:0]  LIGHT_GREEN = 2'b10;

   logic        meta_q, meta_d;
   logic        sync_q, sync_d;
   state_t      state_q, state_d;
   logic [7:0]  qual_cnt_q, qual_cnt_d;
   logic [15:0] stuck_cnt_q, stuck_cnt_d;
   logic        fault_q, fault_d;
   logic        sensor_q, sensor_d;
   logic        green;

   // 2'b11 is illegal and deliberately falls into "not green"
   assign green = (light == LIGHT_GREEN);

   always_comb begin
      meta_d      = raw;
      sync_d      = meta_q;
      state_d     = state_q;
      qual_cnt_d  = qual_cnt_q;
      stuck_cnt_d = stuck_cnt_q;
      fault_d     = fault_q;

      case (state_q)
         ST_IDLE: begin
            if (sync_q) begin
               if (QUAL_LAST == 8'd0) begin
                  state_d    = green ? ST_SERVED : ST_REQ;
                  qual_cnt_d = 8'd0;
               end else begin
                  state_d    = ST_QUAL;
                  qual_cnt_d = 8'd1;
               end
            end
         end
         ST_QUAL: begin
            if (!sync_q) begin
               state_d    = ST_IDLE;
               qual_cnt_d = 8'd0;
            end else if (qual_cnt_q >= QUAL_LAST) begin
               state_d    = green ? ST_SERVED : ST_REQ;
               qual_cnt_d = 8'd0;
            end else begin
               qual_cnt_d = qual_cnt_q + 8'd1;
            end
         end
         ST_REQ: begin
            if (green) begin
               state_d = ST_SERVED;
            end
         end
         ST_SERVED: begin
            if (!green) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            qual_cnt_d = 8'd0;
         end
      endcase

      // Stuck watchdog runs regardless of the FSM so a jammed loop is caught in any state
      if (!sync_q) begin
         stuck_cnt_d = 16'd0;
      end else if (stuck_cnt_q != STUCK_MAX) begin
         stuck_cnt_d = stuck_cnt_q + 16'd1;
      end

      if (stuck_cnt_d == STUCK_MAX) begin
         fault_d = 1'b1;
      end

      sensor_d = (state_d == ST_REQ) || fault_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q      <= 1'b0;
         sync_q      <= 1'b0;
         state_q     <= ST_IDLE;
         qual_cnt_q  <= 8'd0;
         stuck_cnt_q <= 16'd0;
         fault_q     <= 1'b0;
         sensor_q    <= 1'b0;
      end else begin
         meta_q      <= meta_d;
         sync_q      <= sync_d;
         state_q     <= state_d;
         qual_cnt_q  <= qual_cnt_d;
         stuck_cnt_q <= stuck_cnt_d;
         fault_q     <= fault_d;
         sensor_q    <= sensor_d;
      end
   end

   assign sensor = sensor_q;
   assign fault  = fault_q;

endmodule

module traffic_sensor_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int STUCK_CYCLES    = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw_a,
   input  logic       raw_b,
   input  logic [1:0] light_a,
   input  logic [1:0] light_b,
   output logic       sensor_a,
   output logic       sensor_b,
   output logic       fault_a,
   output logic       fault_b
);

   traffic_sensor_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
   ) u_chan_a (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw_a),
      .light  (light_a),
      .sensor (sensor_a),
      .fault  (fault_a)
   );

   traffic_sensor_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
   ) u_chan_b (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw_b),
      .light  (light_b),
      .sensor (sensor_b),
      .fault  (fault_b)
   );

endmodule
